ring_inject_arbiter: RTL and testbench
======================================

RING_INJECT_ARBITER -- requirements
Module: ring_inject_arbiter

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 16, consecutive empty-ring cycles required before DONE.
REQ-002 Parameter widths come from MD_pkg: OFFSET_PKT_STRUCT_WIDTH, GLOBAL_CELL_ID_WIDTH (G), NB_CELL_COUNT_WIDTH (L).
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 i_start  in  1  single-cycle pulse that begins an injection phase.
REQ-007 i_ring_pkt / i_ring_gcid / i_ring_lifetime / i_ring_valid  in  OFFSET_PKT_STRUCT_WIDTH / 3G / L / 1  upstream ring slot.
REQ-008 i_local_pkt / i_local_gcid / i_local_lifetime / i_local_valid / i_local_last  in  same widths / 1 / 1  local position requester.
REQ-009 i_remote_pkt / i_remote_gcid / i_remote_lifetime / i_remote_valid / i_remote_last  in  same widths / 1 / 1  remote unpacker requester.
REQ-010 o_ring_pkt / o_ring_gcid / o_ring_lifetime / o_ring_valid  out  same widths / 1  downstream ring slot, registered.
REQ-011 o_local_ack, o_remote_ack  out  1  combinational grant; the requester advances on it.
REQ-012 o_busy  out  1  high in RUN and DRAIN.
REQ-013 o_done  out  1  one-cycle pulse on DRAIN->IDLE.

Function
REQ-014 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on i_start; i_start is ignored outside IDLE.
REQ-015 Pass-through (all states): i_ring_valid=1 with i_ring_lifetime!=0 -> next cycle o_ring_* = input with lifetime-1 and o_ring_valid=1; ring traffic is never stalled.
REQ-016 i_ring_valid=1 with lifetime==0: the packet is consumed (not forwarded), and the slot counts as free.
REQ-017 A slot is free when i_ring_valid=0 or the slot was consumed; with no injection, o_ring_valid=0 and o_ring_pkt/gcid/lifetime=0 next cycle.
REQ-018 Injection occurs only in RUN, only on a free slot, and at most one packet per cycle.
REQ-019 Arbitration is round-robin with a 1-bit pointer rr (0 = local preferred); both valid -> grant the preferred requester; one valid -> grant it; after any grant, rr points to the non-granted requester.
REQ-020 ack is asserted in the same cycle as the grant; the granted packet appears on o_ring_* the next cycle with lifetime unmodified.
REQ-021 ack is never asserted when the corresponding valid is 0, when the slot is occupied, or outside RUN.
REQ-022 local_done and remote_done flags latch when an ack is given with the matching *_last=1.
REQ-023 RUN->DRAIN in the cycle after both flags are set, including when both set in the same cycle.
REQ-024 DRAIN: 16-bit empty counter increments each cycle with i_ring_valid=0 or lifetime==0, and clears otherwise; at count==DRAIN_CYCLES-1 with an empty slot -> IDLE, pulse o_done, clear the flags and the counter.
REQ-025 The counter is cleared on entry to DRAIN; the flags and rr are cleared on IDLE->RUN.

Reset
REQ-026 rst: state=IDLE, rr=0, flags=0, counter=0, o_ring_valid=0, o_ring_pkt/gcid/lifetime=0, o_busy=0, o_done=0.
REQ-027 o_local_ack/o_remote_ack are 0 during the reset cycle.
REQ-028 Reset mid-operation discards the registered output packet and any in-progress phase; no o_done is produced.

Verification
REQ-029 Pass-through: IDLE, i_ring_valid=1 with lifetime=3 for 4 cycles, both requesters valid -> o_ring_valid=1 with lifetime=2 one cycle later, and no acks.
REQ-030 Round-robin: RUN, empty ring, both valid for 4 cycles -> acks local, remote, local, remote; outputs appear one cycle after each ack.
REQ-031 Ring priority: RUN, i_ring_valid=1 with lifetime=5 on cycles 0-2 and remote valid -> o_remote_ack=0 on cycles 0-2 and 1 on cycle 3; a lifetime=0 ring packet on cycle 1 gives an ack on cycle 1 instead.
REQ-032 Termination: local_last acked on cycle 10, remote_last on cycle 12, ring empty, DRAIN_CYCLES=16 -> DRAIN from cycle 13, o_done pulse 16 cycles later, o_busy then 0.
REQ-033 Drain restart: in DRAIN, one forwarded ring packet at empty-count 10 -> counter clears, and o_done is delayed by 11 cycles.
REQ-034 Reset: rst asserted in RUN with o_ring_valid=1 -> next cycle all outputs 0, state IDLE; a following i_start restarts with rr=0.

Source files
------------

// File: rtl/MD_pkg.sv
// MD_pkg: shared packet field widths for the ring datapath.
package MD_pkg;
    parameter int OFFSET_PKT_STRUCT_WIDTH = 32;
    parameter int GLOBAL_CELL_ID_WIDTH = 4;
    parameter int NB_CELL_COUNT_WIDTH = 4;
endpackage

// File: rtl/ring_inject_arbiter_if.sv
// ring_inject_arbiter_if: ring slot, requester and status signals of the injection arbiter.
interface ring_inject_if;
    import MD_pkg::*;
    localparam int P = OFFSET_PKT_STRUCT_WIDTH;
    localparam int G = 3 * GLOBAL_CELL_ID_WIDTH;
    localparam int L = NB_CELL_COUNT_WIDTH;
    logic         i_start;
    logic [P-1:0] i_ring_pkt;
    logic [G-1:0] i_ring_gcid;
    logic [L-1:0] i_ring_lifetime;
    logic         i_ring_valid;
    logic [P-1:0] i_local_pkt;
    logic [G-1:0] i_local_gcid;
    logic [L-1:0] i_local_lifetime;
    logic         i_local_valid;
    logic         i_local_last;
    logic [P-1:0] i_remote_pkt;
    logic [G-1:0] i_remote_gcid;
    logic [L-1:0] i_remote_lifetime;
    logic         i_remote_valid;
    logic         i_remote_last;
    logic [P-1:0] o_ring_pkt;
    logic [G-1:0] o_ring_gcid;
    logic [L-1:0] o_ring_lifetime;
    logic         o_ring_valid;
    logic         o_local_ack;
    logic         o_remote_ack;
    logic         o_busy;
    logic         o_done;
    modport master(
        output i_start, i_ring_pkt, i_ring_gcid, i_ring_lifetime, i_ring_valid,
               i_local_pkt, i_local_gcid, i_local_lifetime, i_local_valid, i_local_last,
               i_remote_pkt, i_remote_gcid, i_remote_lifetime, i_remote_valid, i_remote_last,
        input  o_ring_pkt, o_ring_gcid, o_ring_lifetime, o_ring_valid,
               o_local_ack, o_remote_ack, o_busy, o_done
    );
    modport slave(
        input  i_start, i_ring_pkt, i_ring_gcid, i_ring_lifetime, i_ring_valid,
               i_local_pkt, i_local_gcid, i_local_lifetime, i_local_valid, i_local_last,
               i_remote_pkt, i_remote_gcid, i_remote_lifetime, i_remote_valid, i_remote_last,
        output o_ring_pkt, o_ring_gcid, o_ring_lifetime, o_ring_valid,
               o_local_ack, o_remote_ack, o_busy, o_done
    );
endinterface

// File: rtl/ring_inject_arbiter.sv
// ring_inject_arbiter: forwards ring traffic and injects local/remote packets into free slots round-robin.
module ring_inject_arbiter
    import MD_pkg::*;
#(
    parameter int DRAIN_CYCLES = 16
) (
    input logic clk,
    input logic rst,
    ring_inject_if.slave bus
);
    localparam int P = OFFSET_PKT_STRUCT_WIDTH;
    localparam int G = 3 * GLOBAL_CELL_ID_WIDTH;
    localparam int L = NB_CELL_COUNT_WIDTH;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state_q, state_d;
    logic rr_q, rr_d, ldone_q, ldone_d, rdone_q, rdone_d, done_q, done_d;
    logic [15:0] cnt_q, cnt_d;
    logic [P-1:0] pkt_q, pkt_d;
    logic [G-1:0] gcid_q, gcid_d;
    logic [L-1:0] lt_q, lt_d;
    logic vld_q, vld_d;
    logic fwd, can, gl, gr;
    always_comb begin
        fwd = bus.i_ring_valid && (bus.i_ring_lifetime != '0);
        // expired ring packets are dropped, leaving the slot free for injection
        can = !rst && (state_q == RUN) && !fwd;
        gl = can && bus.i_local_valid && (!bus.i_remote_valid || !rr_q);
        gr = can && bus.i_remote_valid && !gl;
        vld_d = fwd || gl || gr;
        pkt_d = fwd ? bus.i_ring_pkt : gl ? bus.i_local_pkt : gr ? bus.i_remote_pkt : '0;
        gcid_d = fwd ? bus.i_ring_gcid : gl ? bus.i_local_gcid : gr ? bus.i_remote_gcid : '0;
        lt_d = fwd ? bus.i_ring_lifetime - L'(1) : gl ? bus.i_local_lifetime :
               gr ? bus.i_remote_lifetime : '0;
        state_d = state_q;
        rr_d = gl ? 1'b1 : gr ? 1'b0 : rr_q;
        ldone_d = ldone_q | (gl & bus.i_local_last);
        rdone_d = rdone_q | (gr & bus.i_remote_last);
        cnt_d = cnt_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (bus.i_start) begin
                state_d = RUN;
                rr_d = 1'b0;
                ldone_d = 1'b0;
                rdone_d = 1'b0;
            end
            RUN: if (ldone_d && rdone_d) begin
                state_d = DRAIN;
                cnt_d = '0;
            end
            DRAIN: if (fwd) cnt_d = '0;
            else if (cnt_q == 16'(DRAIN_CYCLES - 1)) begin
                state_d = IDLE;
                done_d = 1'b1;
                ldone_d = 1'b0;
                rdone_d = 1'b0;
                cnt_d = '0;
            end else cnt_d = cnt_q + 16'd1;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q <= 1'b0;
            ldone_q <= 1'b0;
            rdone_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q <= '0;
            pkt_q <= '0;
            gcid_q <= '0;
            lt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q <= rr_d;
            ldone_q <= ldone_d;
            rdone_q <= rdone_d;
            done_q <= done_d;
            cnt_q <= cnt_d;
            pkt_q <= pkt_d;
            gcid_q <= gcid_d;
            lt_q <= lt_d;
            vld_q <= vld_d;
        end
    end
    assign bus.o_ring_pkt = pkt_q;
    assign bus.o_ring_gcid = gcid_q;
    assign bus.o_ring_lifetime = lt_q;
    assign bus.o_ring_valid = vld_q;
    assign bus.o_local_ack = gl;
    assign bus.o_remote_ack = gr;
    assign bus.o_busy = state_q != IDLE;
    assign bus.o_done = done_q;
endmodule

// File: tb/tb_ring_inject_arbiter.sv
// tb_ring_inject_arbiter: directed stimulus with queued expectations checked by an independent monitor.
module tb_ring_inject_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_nxt = 1'b1;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] rn = 0, ln = 0, mn = 0;
    logic [47:0] q_ring[$];
    logic [1:0] q_ack[$];
    int q_done[$];
    ring_inject_if bus();
    ring_inject_arbiter #(.DRAIN_CYCLES(16)) dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask
    task automatic step(input bit st, input bit rv, input logic [3:0] rlt,
                        input bit lv, input bit ll, input bit mv, input bit ml, input logic [1:0] ea);
        @(negedge clk);
        rst = rst_nxt;
        bus.i_start = st;
        bus.i_ring_valid = rv;
        bus.i_ring_lifetime = rv ? rlt : 4'd0;
        bus.i_ring_pkt = 32'hC000_0000 + rn;
        bus.i_ring_gcid = 12'hC0C;
        bus.i_local_valid = lv;
        bus.i_local_last = ll;
        bus.i_local_pkt = 32'hA000_0000 + ln;
        bus.i_local_gcid = 12'h111;
        bus.i_local_lifetime = 4'd7;
        bus.i_remote_valid = mv;
        bus.i_remote_last = ml;
        bus.i_remote_pkt = 32'hB000_0000 + mn;
        bus.i_remote_gcid = 12'h222;
        bus.i_remote_lifetime = 4'd9;
        if (rv && rlt != 4'd0) q_ring.push_back({32'hC000_0000 + rn, 12'hC0C, rlt - 4'd1});
        if (ea[0]) begin
            q_ring.push_back({32'hA000_0000 + ln, 12'h111, 4'd7});
            ln++;
        end
        if (ea[1]) begin
            q_ring.push_back({32'hB000_0000 + mn, 12'h222, 4'd9});
            mn++;
        end
        if (ea != 2'b00) q_ack.push_back(ea);
        if (rv) rn++;
    endtask
    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 2'b00);
    endtask
    initial begin
        logic [47:0] e;
        logic [1:0] a;
        forever begin
            @(negedge clk);
            #4;
            a = {bus.o_remote_ack, bus.o_local_ack};
            if (a != 2'b00) begin
                if (q_ack.size() == 0) chk("ack_unexpected", 64'(a), 64'd0);
                else chk("ack", 64'(a), 64'(q_ack.pop_front()));
            end
            if (bus.o_ring_valid) begin
                e = (q_ring.size() == 0) ? 48'hDEAD : q_ring.pop_front();
                chk("ring_out", {bus.o_ring_pkt, bus.o_ring_gcid, bus.o_ring_lifetime}, 64'(e));
            end else chk("ring_empty", {bus.o_ring_pkt, bus.o_ring_gcid, bus.o_ring_lifetime}, 64'd0);
            if (bus.o_done) chk("done_cycle", 64'(cyc), 64'((q_done.size() == 0) ? -1 : q_done.pop_front()));
        end
    end
    initial begin
        int t;
        bus.i_start = 0; bus.i_ring_valid = 0; bus.i_local_valid = 0; bus.i_remote_valid = 0;
        bus.i_ring_pkt = 0; bus.i_ring_gcid = 0; bus.i_ring_lifetime = 0;
        bus.i_local_pkt = 0; bus.i_local_gcid = 0; bus.i_local_lifetime = 0; bus.i_local_last = 0;
        bus.i_remote_pkt = 0; bus.i_remote_gcid = 0; bus.i_remote_lifetime = 0; bus.i_remote_last = 0;
        // reset with both requesters valid: no acks, all outputs zero
        repeat (2) step(0, 0, 0, 1, 0, 1, 0, 2'b00);
        #4;
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        chk("rst_valid", 64'(bus.o_ring_valid), 64'd0);
        rst_nxt = 0;
        repeat (4) step(0, 1, 3, 1, 0, 1, 0, 2'b00);
        step(0, 1, 0, 1, 0, 1, 0, 2'b00);
        step(0, 0, 0, 1, 0, 1, 0, 2'b00);
        #4 chk("idle_busy", 64'(bus.o_busy), 64'd0);
        step(1, 0, 0, 0, 0, 0, 0, 2'b00);
        step(0, 0, 0, 1, 0, 1, 0, 2'b01);
        #4 chk("run_busy", 64'(bus.o_busy), 64'd1);
        step(0, 0, 0, 1, 0, 1, 0, 2'b10);
        step(0, 0, 0, 1, 0, 1, 0, 2'b01);
        step(0, 0, 0, 1, 0, 1, 0, 2'b10);
        repeat (3) step(0, 1, 5, 0, 0, 1, 0, 2'b00);
        step(0, 0, 0, 0, 0, 1, 0, 2'b10);
        step(0, 1, 5, 0, 0, 1, 0, 2'b00);
        step(0, 1, 0, 0, 0, 1, 0, 2'b10);
        step(0, 1, 5, 0, 0, 1, 0, 2'b00);
        step(0, 0, 0, 1, 0, 0, 0, 2'b01);
        step(0, 0, 0, 1, 0, 1, 0, 2'b10);
        // termination: local last, then remote last
        step(0, 0, 0, 1, 1, 1, 0, 2'b01);
        step(0, 0, 0, 0, 0, 1, 0, 2'b10);
        step(0, 0, 0, 0, 0, 1, 1, 2'b10);
        t = cyc;
        q_done.push_back(t + 17);
        step(0, 0, 0, 1, 0, 1, 0, 2'b00);
        #4 chk("drain_busy", 64'(bus.o_busy), 64'd1);
        step(1, 0, 0, 0, 0, 0, 0, 2'b00);
        repeat (14) idle_step();
        #4 chk("pre_done_busy", 64'(bus.o_busy), 64'd1);
        idle_step();
        #4 chk("post_done_busy", 64'(bus.o_busy), 64'd0);
        // drain restart: one forwarded packet at empty-count 10
        step(1, 0, 0, 0, 0, 0, 0, 2'b00);
        step(0, 0, 0, 1, 1, 1, 1, 2'b01);
        step(0, 0, 0, 0, 0, 1, 1, 2'b10);
        t = cyc;
        q_done.push_back(t + 28);
        for (int i = 1; i <= 27; i++) step(0, i == 11, 4, 0, 0, 0, 0, 2'b00);
        #4 chk("restart_busy", 64'(bus.o_busy), 64'd1);
        idle_step();
        #4 chk("restart_idle", 64'(bus.o_busy), 64'd0);
        // reset mid-run with a packet on the output, rr left pointing at remote
        step(1, 0, 0, 0, 0, 0, 0, 2'b00);
        step(0, 0, 0, 1, 0, 0, 0, 2'b01);
        rst_nxt = 1;
        step(0, 0, 0, 1, 0, 1, 0, 2'b00);
        rst_nxt = 0;
        idle_step();
        #4;
        chk("midrst_valid", 64'(bus.o_ring_valid), 64'd0);
        chk("midrst_busy", 64'(bus.o_busy), 64'd0);
        step(1, 0, 0, 0, 0, 0, 0, 2'b00);
        step(0, 0, 0, 1, 0, 1, 0, 2'b01);
        repeat (3) idle_step();
        #4;
        chk("ring_q_left", 64'(q_ring.size()), 64'd0);
        chk("ack_q_left", 64'(q_ack.size()), 64'd0);
        chk("done_q_left", 64'(q_done.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
